// File: rtl/alu_pkg.sv
// Shared types and helpers for the byte-serial add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned ALU_BYTE_W = 8;

  // Sum bit i = P[i] ^ carry into bit i (carry out of bit i-1, or the byte carry-in).
  function automatic logic [ALU_BYTE_W-1:0] byte_sum(
    input logic [ALU_BYTE_W-1:0] p,
    input logic [ALU_BYTE_W-1:0] carrys,
    input logic                  c_in
  );
    return p ^ {carrys[ALU_BYTE_W-2:0], c_in};
  endfunction

endpackage

// File: rtl/alu_pg_slice.sv
// One byte of propagate/generate plus sum formation from externally computed carries.
module alu_pg_slice
  import alu_pkg::*;
(
  input  logic [ALU_BYTE_W-1:0] a,
  input  logic [ALU_BYTE_W-1:0] b,
  input  logic                  carry,
  input  logic [ALU_BYTE_W-1:0] carrys,
  output logic [ALU_BYTE_W-1:0] p,
  output logic [ALU_BYTE_W-1:0] g,
  output logic                  c_in,
  output logic [ALU_BYTE_W-1:0] sum
);

  assign p    = a ^ b;
  assign g    = a & b;
  assign c_in = carry;
  assign sum  = byte_sum(p, carrys, carry);

endmodule

// File: rtl/alu_pg_sequencer.sv
// Byte-serial WIDTH-bit add/subtract driving an external 8-bit carry-lookahead unit.
// Optional ALU_PG_CHECK_EN: local ripple cross-check of LA_CARRYS, sticky ERR.
module alu_pg_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CARRY_IN,
  output logic [7:0]       LA_P,
  output logic [7:0]       LA_G,
  output logic             LA_C_IN,
  input  logic [7:0]       LA_CARRYS,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_CARRY,
  output logic             OUT_OVERFLOW,
  output logic             OUT_ZERO,
  output logic             ERR
);

  localparam int unsigned NBYTES   = WIDTH / ALU_BYTE_W;
  localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]      a_reg, b_reg, sum_work, sum_next;
  logic                  carry_reg;
  logic [IDX_W-1:0]      idx;
  logic [ALU_BYTE_W-1:0] a_byte, b_byte, p, g, sum_byte;
  logic                  c_in;
  logic                  accept, run, last;

  assign a_byte = a_reg[idx*ALU_BYTE_W +: ALU_BYTE_W];
  assign b_byte = b_reg[idx*ALU_BYTE_W +: ALU_BYTE_W];

  alu_pg_slice u_slice (
    .a      (a_byte),
    .b      (b_byte),
    .carry  (carry_reg),
    .carrys (LA_CARRYS),
    .p      (p),
    .g      (g),
    .c_in   (c_in),
    .sum    (sum_byte)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    run        = 1'b0;
    unique case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = IN_VALID && IN_READY;
  assign last    = (idx == LAST_IDX);
  assign LA_P    = run ? p : '0;
  assign LA_G    = run ? g : '0;
  assign LA_C_IN = run ? c_in : 1'b0;

  always_comb begin
    sum_next = sum_work;
    sum_next[idx*ALU_BYTE_W +: ALU_BYTE_W] = sum_byte;
  end

  // Bytes accumulate in sum_work so OUT_SUM holds the previous result until the final byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      idx          <= '0;
      sum_work     <= '0;
      OUT_SUM      <= '0;
      OUT_CARRY    <= 1'b0;
      OUT_OVERFLOW <= 1'b0;
      OUT_ZERO     <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= SUB ? ~B : B;
      carry_reg <= CARRY_IN;
      idx       <= '0;
      sum_work  <= '0;
    end else if (run) begin
      sum_work  <= sum_next;
      carry_reg <= LA_CARRYS[7];
      if (last) begin
        idx          <= '0;
        OUT_SUM      <= sum_next;
        OUT_CARRY    <= LA_CARRYS[7];
        OUT_OVERFLOW <= LA_CARRYS[7] ^ LA_CARRYS[6];
        OUT_ZERO     <= (sum_next == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef ALU_PG_CHECK_EN
  logic [ALU_BYTE_W-1:0] ripple;
  logic                  rc;

  always_comb begin
    rc     = c_in;
    ripple = '0;
    for (int unsigned i = 0; i < ALU_BYTE_W; i++) begin
      rc        = (rc & p[i]) | g[i];
      ripple[i] = rc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                            ERR <= 1'b0;
    else if (run && ripple != LA_CARRYS) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pg_sequencer.sv
// Directed bench for alu_pg_sequencer (WIDTH=32) with a behavioural lookahead unit.
module tb_alu_pg_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A, B;
  logic        SUB, CARRY_IN;
  logic [7:0]  LA_P, LA_G;
  logic        LA_C_IN;
  logic [7:0]  LA_CARRYS;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_SUM;
  logic        OUT_CARRY, OUT_OVERFLOW, OUT_ZERO, ERR;

  logic flip = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  alu_pg_sequencer #(.WIDTH(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .A            (A),
    .B            (B),
    .SUB          (SUB),
    .CARRY_IN     (CARRY_IN),
    .LA_P         (LA_P),
    .LA_G         (LA_G),
    .LA_C_IN      (LA_C_IN),
    .LA_CARRYS    (LA_CARRYS),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_SUM      (OUT_SUM),
    .OUT_CARRY    (OUT_CARRY),
    .OUT_OVERFLOW (OUT_OVERFLOW),
    .OUT_ZERO     (OUT_ZERO),
    .ERR          (ERR)
  );

  // External lookahead unit; flip corrupts carry 3 for fault injection.
  always_comb begin
    logic c;
    c = LA_C_IN;
    LA_CARRYS = '0;
    for (int i = 0; i < 8; i++) begin
      c = (c & LA_P[i]) | LA_G[i];
      LA_CARRYS[i] = c;
    end
    if (flip) LA_CARRYS[3] = ~LA_CARRYS[3];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
    int n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("in_ready_before_op", 32'(IN_READY), 32'd1);
    A = a; B = b; SUB = sub; CARRY_IN = cin; IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] sum,
                             input logic c, input logic o, input logic z);
    int lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, OUT_SUM, sum);
    check({tag, "_carry"}, 32'(OUT_CARRY), 32'(c));
    check({tag, "_ovf"}, 32'(OUT_OVERFLOW), 32'(o));
    check({tag, "_zero"}, 32'(OUT_ZERO), 32'(z));
  endtask

  task automatic handshake(input string tag);
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    OUT_READY = 1'b0;
    check({tag, "_valid_drop"}, 32'(OUT_VALID), 32'd0);
  endtask

  logic exp_err;

  initial begin
`ifdef ALU_PG_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; SUB = 1'b0; CARRY_IN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_sum", OUT_SUM, 32'h0);
    check("rst_flags", {29'd0, OUT_CARRY, OUT_OVERFLOW, OUT_ZERO}, 32'h0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_la_p", 32'(LA_P), 32'd0);
    RST = 1'b0;

    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("op1_la_p", 32'(LA_P), 32'h0000_00FE);
    check("op1_la_g", 32'(LA_G), 32'h0000_0001);
    check("op1_la_cin", 32'(LA_C_IN), 32'd0);
    wait_result("op1", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    handshake("op1");
    check("op1_bubble_ready", 32'(IN_READY), 32'd1);

    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result("op2", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    handshake("op2");

    start_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    wait_result("sub1", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    handshake("sub1");

    start_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    wait_result("sub2", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    handshake("sub2");

    start_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    wait_result("cin", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    handshake("cin");

    // Back-pressure: result held while a new request waits.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_result("hold", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    A = 32'h0000_0010; B = 32'h0000_0020; SUB = 1'b0; CARRY_IN = 1'b0; IN_VALID = 1'b1;
    repeat (10) begin
      @(posedge CLK);
      @(negedge CLK);
      check("hold_valid", 32'(OUT_VALID), 32'd1);
      check("hold_in_ready", 32'(IN_READY), 32'd0);
      check("hold_sum", OUT_SUM, 32'h2345_6789);
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("bubble_in_ready", 32'(IN_READY), 32'd1);
    check("bubble_out_valid", 32'(OUT_VALID), 32'd0);
    check("bubble_sum_kept", OUT_SUM, 32'h2345_6789);
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    check("next_accepted", 32'(IN_READY), 32'd0);
    wait_result("next", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    handshake("next");

    // Abort after two RUN edges.
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("abort_in_ready", 32'(IN_READY), 32'd1);
    check("abort_out_valid", 32'(OUT_VALID), 32'd0);
    check("abort_sum", OUT_SUM, 32'h0);
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result("post_abort", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    handshake("post_abort");

    // Corrupt the lookahead on byte 1 only.
    start_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
    check("err_before", 32'(ERR), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    flip = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    flip = 1'b0;
    check("err_set", 32'(ERR), 32'(exp_err));
    begin
      int n = 0;
      while (!OUT_VALID && n < 20) begin
        @(negedge CLK);
        n++;
      end
    end
    check("err_op_done", 32'(OUT_VALID), 32'd1);
    handshake("err_op");
    repeat (3) @(negedge CLK);
    check("err_sticky", 32'(ERR), 32'(exp_err));
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("err_cleared", 32'(ERR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
